mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style HI/LO unit: radix-2 shift-add multiply and restoring divide.
// An operation occupies 34 cycles from the start edge; MTHI/MTLO writes land only while idle.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [DATA_WIDTH-1:0]   readData1,
    input  logic [DATA_WIDTH-1:0]   readData2,
    input  logic                    mtWrite,
    input  logic                    mtSel,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0]   lo
);

    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    logic [1:0]    r_state;
    logic [5:0]    r_count;
    logic          r_isDiv;
    logic          r_negRes;
    logic          r_negRem;
    logic          r_divZero;
    logic [W-1:0]  r_dividend;
    logic [W2-1:0] r_acc;
    logic [W2-1:0] r_mcand;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;

    logic          w_signedOp;
    logic          w_negA;
    logic          w_negB;
    logic [W-1:0]  w_magA;
    logic [W-1:0]  w_magB;
    logic [W2-1:0] w_mulAcc;
    logic [W:0]    w_shift;
    logic          w_fits;
    logic [W-1:0]  w_diff;
    logic [W-1:0]  w_nextRem;
    logic [W-1:0]  w_nextQuo;
    logic [W2-1:0] w_prod;
    logic [W-1:0]  w_quo;
    logic [W-1:0]  w_rem;

    // op[0] clear means signed (MULT/DIV); magnitudes are taken before the datapath sees them
    assign w_signedOp = ~op[0];
    assign w_negA     = w_signedOp & readData1[W-1];
    assign w_negB     = w_signedOp & readData2[W-1];
    assign w_magA     = w_negA ? -readData1 : readData1;
    assign w_magB     = w_negB ? -readData2 : readData2;

    assign w_mulAcc   = r_b[0] ? (r_acc + r_mcand) : r_acc;

    // Divide keeps remainder in r_acc upper half and the dividend/quotient in the lower half
    assign w_shift    = {r_acc[W2-1:W], r_acc[W-1]};
    assign w_fits     = (w_shift >= {1'b0, r_b});
    assign w_diff     = w_shift[W-1:0] - r_b;
    assign w_nextRem  = w_fits ? w_diff : w_shift[W-1:0];
    assign w_nextQuo  = {r_acc[W-2:0], w_fits};

    assign w_prod     = r_negRes ? -r_acc : r_acc;
    assign w_quo      = r_negRes ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem      = r_negRem ? -r_acc[W2-1:W] : r_acc[W2-1:W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_count    <= 6'd0;
            r_isDiv    <= 1'b0;
            r_negRes   <= 1'b0;
            r_negRem   <= 1'b0;
            r_divZero  <= 1'b0;
            r_dividend <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_BUSY;
                        r_count    <= 6'd0;
                        r_isDiv    <= op[1];
                        r_negRes   <= ((op == OP_MULT) || (op == OP_DIV)) && (readData1[W-1] ^ readData2[W-1]);
                        r_negRem   <= (op == OP_DIV) && readData1[W-1];
                        r_divZero  <= (readData2 == '0);
                        r_dividend <= readData1;
                        r_acc      <= op[1] ? {{W{1'b0}}, w_magA} : '0;
                        r_mcand    <= {{W{1'b0}}, w_magA};
                        r_b        <= w_magB;
                    end else if (mtWrite) begin
                        if (mtSel) begin
                            r_hi <= readData1;
                        end else begin
                            r_lo <= readData1;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_count == 6'd32) begin
                        r_state <= S_DONE;
                        if (!r_isDiv) begin
                            r_hi <= w_prod[W2-1:W];
                            r_lo <= w_prod[W-1:0];
                        end else if (r_divZero) begin
                            r_hi <= r_dividend;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end else begin
                        r_count <= r_count + 6'd1;
                        if (r_isDiv) begin
                            r_acc <= {w_nextRem, w_nextQuo};
                        end else begin
                            r_acc   <= w_mulAcc;
                            r_mcand <= {r_mcand[W2-2:0], 1'b0};
                            r_b     <= {1'b0, r_b[W-1:1]};
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: exact-latency checks of every op, MTHI/MTLO
// priority, ignored inputs during an operation, and reset abort.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        mtWrite;
    logic        mtSel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit seenDone;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .readData1 (readData1),
        .readData2 (readData2),
        .mtWrite   (mtWrite),
        .mtSel     (mtSel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic mw, input logic ms);
        start     = s;
        op        = o;
        readData1 = a;
        readData2 = b;
        mtWrite   = mw;
        mtSel     = ms;
    endtask

    // Start at edge N, then check the exact cycle HI/LO change and busy drops.
    task automatic runOp(input string tag, input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic [31:0] preHi, input logic [31:0] preLo,
                         input bit disturb, input bit mtAtStart);
        @(negedge clk);
        applyStimulus(1'b1, opc, a, b, mtAtStart, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            if (disturb) begin
                applyStimulus(1'b1, 2'($urandom), $urandom, $urandom, 1'b1, 1'($urandom));
            end
            @(posedge clk);
            #1;
        end
        checkOutput({tag, " done@N+32"}, {31'b0, done}, 32'd0);
        checkOutput({tag, " busy@N+32"}, {31'b0, busy}, 32'd1);
        checkOutput({tag, " hi held"}, hi, preHi);
        checkOutput({tag, " lo held"}, lo, preLo);
        @(posedge clk);
        #1;
        checkOutput({tag, " done@N+33"}, {31'b0, done}, 32'd1);
        checkOutput({tag, " busy@N+33"}, {31'b0, busy}, 32'd1);
        checkOutput({tag, " hi"}, hi, expHi);
        checkOutput({tag, " lo"}, lo, expLo);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done@N+34"}, {31'b0, done}, 32'd0);
        checkOutput({tag, " busy@N+34"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, " hi@N+34"}, hi, expHi);
        checkOutput({tag, " lo@N+34"}, lo, expLo);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b1, 2'b01, 32'hDEADBEEF, 32'h00000003, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;

        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 32'h12345678, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("mtlo lo", lo, 32'h12345678);
        checkOutput("mtlo hi", hi, 32'd0);
        checkOutput("mtlo busy", {31'b0, busy}, 32'd0);

        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 32'hAABBCCDD, 32'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("mthi hi", hi, 32'hAABBCCDD);
        checkOutput("mthi lo", lo, 32'h12345678);

        runOp("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
              32'hAABBCCDD, 32'h12345678, 1'b0, 1'b1);
        runOp("mult -3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB,
              32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
        runOp("div -7/2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        runOp("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
        runOp("divu by0", 2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 1'b0, 1'b0);
        runOp("divu 1000/7", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142,
              32'h00000064, 32'hFFFFFFFF, 1'b0, 1'b0);
        runOp("mult -5x-6", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E,
              32'd6, 32'd142, 1'b0, 1'b0);
        runOp("div 7/-2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD,
              32'h00000000, 32'h0000001E, 1'b0, 1'b0);

        @(negedge clk);
        applyStimulus(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'b10, 32'h00000009, 32'h00000003, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        checkOutput("abort done", {31'b0, done}, 32'd0);
        seenDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seenDone = 1'b1;
        end
        checkOutput("abort no done", {31'b0, seenDone}, 32'd0);
        checkOutput("abort lo after", lo, 32'd0);

        runOp("multu 2x3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6,
              32'd0, 32'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
